// File: rtl/tipi_pkg.sv
// Shared constants and state encoding for the Pi-side byte receiver.
package tipi_pkg;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/pi_byte_rx_if.sv
// Consumer-side bundle: holding register, flags and the ack/clear pulses.
interface pi_byte_rx_if
    import tipi_pkg::*;
#(
    parameter int WIDTH = tipi_pkg::WIDTH
) ();

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             rd_ack;
    logic             overrun;
    logic             frame_err;
    logic             clr_err;

    modport master (
        output data,
        output valid,
        output overrun,
        output frame_err,
        input  rd_ack,
        input  clr_err
    );

    modport slave (
        input  data,
        input  valid,
        input  overrun,
        input  frame_err,
        output rd_ack,
        output clr_err
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r <= '0;
        else       r <= {r[STAGES-2:0], d};
    end

    assign q = r[STAGES-1];

endmodule

// File: rtl/pi_byte_rx.sv
// Serial-in parallel-out receiver: MSB-first bytes from the Pi into a
// holding register with valid/ack handshake, overrun and abort flags.
module pi_byte_rx
    import tipi_pkg::*;
#(
    parameter int WIDTH       = tipi_pkg::WIDTH,
    parameter int SYNC_STAGES = tipi_pkg::SYNC_STAGES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sclk,
    input  logic            sin,
    input  logic            select,
    pi_byte_rx_if.master    rx
);

    localparam int CW = $clog2(WIDTH);

    logic sclk_s, sin_s, sel_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sin (
        .clk(clk), .reset(reset), .d(sin), .q(sin_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sel (
        .clk(clk), .reset(reset), .d(select), .q(sel_s)
    );

    // Rise is registered; sin and select ride the same stage to stay aligned.
    logic sclk_d, rise_q, sin_q, sel_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_d <= 1'b0;
            rise_q <= 1'b0;
            sin_q  <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            rise_q <= sclk_s & ~sclk_d;
            sin_q  <= sin_s;
            sel_q  <= sel_s;
        end
    end

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic [WIDTH-1:0] byte_w;
    logic             done, abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shift <= shift_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        done    = 1'b0;
        abort   = 1'b0;
        byte_w  = {shift[WIDTH-2:0], sin_q};
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (sel_q) state_n = SHIFT;
            end
            SHIFT: begin
                if (!sel_q) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    abort   = (cnt != '0);
                end else if (rise_q) begin
                    shift_n = byte_w;
                    if (cnt == CW'(WIDTH - 1)) begin
                        done  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    logic [WIDTH-1:0] data_q;
    logic             valid_q, ovr_q, ferr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            if (done) begin
                if (!valid_q || rx.rd_ack) begin
                    data_q  <= byte_w;
                    valid_q <= 1'b1;
                end
            end else if (rx.rd_ack) begin
                valid_q <= 1'b0;
            end
            // Set wins over a simultaneous clear.
            if (done && valid_q && !rx.rd_ack) ovr_q <= 1'b1;
            else if (rx.clr_err)               ovr_q <= 1'b0;
            if (abort)                         ferr_q <= 1'b1;
            else if (rx.clr_err)               ferr_q <= 1'b0;
        end
    end

    assign rx.data      = data_q;
    assign rx.valid     = valid_q;
    assign rx.overrun   = ovr_q;
    assign rx.frame_err = ferr_q;

endmodule

// File: doc/pi_byte_rx.md
# pi_byte_rx

Serial-in, parallel-out receive stage that takes bytes the Raspberry Pi shifts toward the CPLD, the counterpart of the parallel-load/serial-out transmit shifter on the same select/clock bus. All Pi-side inputs are synchronised into the CPLD system clock and assembled MSB-first into a byte. Each completed byte goes into a holding register with a valid/acknowledge handshake to the TI-side register file. Overrun and aborted-frame conditions are flagged.

## Interface
- WIDTH, 8: bits per transfer.
- SYNC_STAGES, 2: flip-flops per input synchroniser (≥2).
- clk  in  1  CPLD system clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- sclk  in  1  Pi serial clock, asynchronous to clk; data sampled on its rising edge.
- sin  in  1  Pi serial data, MSB first.
- select  in  1  Pi frame select, active-high, asynchronous.
- data  out  WIDTH  holding register, last completed byte.
- valid  out  1  data holds an unconsumed byte.
- rd_ack  in  1  one-clk pulse from consumer; clears valid.
- overrun  out  1  sticky: byte completed while valid was set.
- frame_err  out  1  sticky: select dropped mid-byte.
- clr_err  in  1  one-clk pulse; clears overrun and frame_err.

## Operation
- sclk, sin, select each pass through a SYNC_STAGES synchroniser; sin and sclk share the same depth so they stay aligned.
- Rise event = synchronised sclk high AND previous-cycle synchronised sclk low.
- FSM states: IDLE, SHIFT.
  - IDLE: bit counter 0; rise events ignored; synchronised select high → SHIFT.
  - SHIFT: on rise, shift = {shift[WIDTH-2:0], sin_s}, counter +1.
  - On the rise where counter == WIDTH-1: assembled byte {shift[WIDTH-2:0], sin_s} becomes complete; counter → 0; stay in SHIFT.
  - Synchronised select low → IDLE. If counter ≠ 0, the partial byte is discarded and frame_err is set.
- Byte completion:
  - valid low: data ← byte; valid ← 1.
  - valid high, rd_ack same cycle: data ← byte; valid stays 1; no overrun.
  - valid high, no rd_ack: byte dropped; data unchanged; overrun ← 1.
- rd_ack with no completion clears valid; data is unchanged. rd_ack while valid is low is a no-op.
- clr_err and a new error event in the same cycle: the flag stays set (the set wins).
- Reset values: data = 0, valid = 0, overrun = 0, frame_err = 0, counter = 0, shift = 0, state IDLE, synchronisers 0.
- Reset asserted mid-byte: the partial byte is lost and no flag is set. After release, the first select-high starts a fresh byte.

## Timing
- Latency: valid and data update on the clk edge SYNC_STAGES+1 cycles after the first clk edge that samples sclk high at the pin.
- sclk high and low phases: each ≥ SYNC_STAGES+1 clk periods. Shorter pulses may be missed; this is not detected.
- sin must be stable from 1 clk period before to 1 clk period after the sclk rising edge.
- select must rise ≥ 1 clk period before the first sclk rise of a frame.
- select must fall ≥ 1 clk period after the last sclk rise.
- rd_ack, clr_err: synchronous to clk, single-cycle. A held level acts as a repeated pulse.
- Back-to-back bytes with no gap are supported under continuous select.

## Structure
- Shared package `tipi_pkg`:
  - WIDTH default.
  - SYNC_STAGES default.
  - FSM state encoding (IDLE = 0, SHIFT = 1).
- Sub-module `sync_ff` (parameter STAGES; in/out 1 bit; async reset to 0), instantiated for sclk, sin and select.
- Counter width $clog2(WIDTH).
- Edge detect, FSM and holding-register logic live in pi_byte_rx.

## Test plan
- Single byte: select high, shift 0xA5 MSB first with sclk 4 clk high / 4 low → valid rises SYNC_STAGES+1 clks after the 8th rise; data = 0xA5; flags 0.
- Handshake / back-to-back: send 0x3C then 0xC3 under one select, rd_ack after each valid → data 0x3C then 0xC3; valid pulses twice; overrun 0.
- Overrun: send 0x11 without ack, then 0x22 → data stays 0x11; overrun = 1. clr_err → overrun = 0.
- Ack coincident with completion: pulse rd_ack on the exact cycle the 2nd byte (0x5A) completes → valid stays 1; data = 0x5A; overrun 0.
- Abort: select low after 3 bits, then a full 0x7E frame → frame_err = 1; data = 0x7E (partial bits not mixed in).
- Reset mid-byte: async reset after 5 bits, release, send 0x81 → every output reset to 0 immediately on assertion; next byte = 0x81; frame_err 0.
